// File: rtl/bus_arbiter.sv
// Bus arbiter that hands the tv80s memory/IO bus to a DMA master.
// The arbiter requests the bus with busrq_n and waits for busak_n.
// Each grant is capped at MAX_BURST cycles. A CPU-owned cooldown window
// separates consecutive grants, and a request that is never acknowledged
// is abandoned after ACK_TIMEOUT cycles. Every output is a flop.
module bus_arbiter #(
    parameter int MAX_BURST   = 16,
    parameter int CPU_WINDOW  = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dma_req,
    output logic       dma_gnt,
    output logic       busrq_n,
    input  logic       busak_n,
    output logic       bus_sel,
    output logic       timeout_err,
    output logic [7:0] grant_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_GRANT    = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    localparam logic [7:0] BURST_LAST  = 8'(MAX_BURST - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] WINDOW_LOAD = 8'(CPU_WINDOW);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic [7:0] r_burst_cnt;
    logic [7:0] r_window_cnt;
    logic [7:0] r_grant_count;
    logic       r_busrq_n;
    logic       r_dma_gnt;
    logic       r_bus_sel;
    logic       r_timeout_err;

    state_t     w_state_nxt;
    logic [7:0] w_wait_nxt;
    logic [7:0] w_burst_nxt;
    logic [7:0] w_window_nxt;
    logic       w_timeout;
    logic       w_grant_done;

    // Next-state, next-counter and event decode for the arbitration FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt  = ST_IDLE;
        w_wait_nxt   = 8'd0;
        w_burst_nxt  = 8'd0;
        w_window_nxt = 8'd0;
        w_timeout    = 1'b0;
        w_grant_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dma_req) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                // An acknowledge beats the timeout, and the timeout beats a dropped request.
                if (!busak_n) begin
                    w_state_nxt = dma_req ? ST_GRANT : ST_RELEASE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end else if (!dma_req) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REQ;
                    w_wait_nxt  = r_wait_cnt + 8'd1;
                end
            end
            ST_GRANT: begin
                // If busak_n deasserts, the core has reclaimed the bus; give it up at once.
                if (busak_n || !dma_req || (r_burst_cnt == BURST_LAST)) begin
                    w_state_nxt  = ST_RELEASE;
                    w_grant_done = 1'b1;
                end else begin
                    w_state_nxt = ST_GRANT;
                    w_burst_nxt = r_burst_cnt + 8'd1;
                end
            end
            ST_RELEASE: begin
                if (!busak_n) begin
                    w_state_nxt = ST_RELEASE;
                end else if (CPU_WINDOW == 0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt  = ST_COOLDOWN;
                    w_window_nxt = WINDOW_LOAD;
                end
            end
            ST_COOLDOWN: begin
                // dma_req is deliberately ignored here, so the CPU keeps its full window.
                if (r_window_cnt <= 8'd1) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt  = ST_COOLDOWN;
                    w_window_nxt = r_window_cnt - 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counters and outputs are registered; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments, so every flop samples pre-edge values.
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= 8'd0;
            r_burst_cnt   <= 8'd0;
            r_window_cnt  <= 8'd0;
            r_grant_count <= 8'd0;
            r_busrq_n     <= 1'b1;
            r_dma_gnt     <= 1'b0;
            r_bus_sel     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_burst_cnt   <= w_burst_nxt;
            r_window_cnt  <= w_window_nxt;
            if (w_grant_done && (r_grant_count != 8'hFF))
                r_grant_count <= r_grant_count + 8'd1;
            r_busrq_n     <= !((w_state_nxt == ST_REQ) || (w_state_nxt == ST_GRANT));
            r_dma_gnt     <= (w_state_nxt == ST_GRANT);
            r_bus_sel     <= (w_state_nxt == ST_GRANT);
            r_timeout_err <= w_timeout;
        end
    end

    assign dma_gnt     = r_dma_gnt;
    assign busrq_n     = r_busrq_n;
    assign bus_sel     = r_bus_sel;
    assign timeout_err = r_timeout_err;
    assign grant_count = r_grant_count;
    assign state       = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter, built with MAX_BURST=4,
// CPU_WINDOW=8 and ACK_TIMEOUT=5. Each step drives one cycle of inputs
// and queues the outputs expected after that clock edge. The queued entry
// is popped and compared against the DUT once the edge has passed.
module tb_bus_arbiter;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_GNT  = 3'd2;
    localparam logic [2:0] S_REL  = 3'd3;
    localparam logic [2:0] S_COOL = 3'd4;

    logic       clk;
    logic       reset;
    logic       dma_req;
    logic       busak_n;
    logic       dma_gnt;
    logic       busrq_n;
    logic       bus_sel;
    logic       timeout_err;
    logic [7:0] grant_count;
    logic [2:0] state;

    int n_tests;
    int n_fail;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       to;
        logic [7:0] gc;
    } exp_t;

    exp_t sb_q[$];

    bus_arbiter #(
        .MAX_BURST  (4),
        .CPU_WINDOW (8),
        .ACK_TIMEOUT(5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dma_req    (dma_req),
        .dma_gnt    (dma_gnt),
        .busrq_n    (busrq_n),
        .busak_n    (busak_n),
        .bus_sel    (bus_sel),
        .timeout_err(timeout_err),
        .grant_count(grant_count),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare them.
    task automatic step(input string tag, input logic d, input logic a, input logic rst,
                        input logic [2:0] st, input logic to, input logic [7:0] gc);
        exp_t e;
        exp_t got;
        logic rq_n_exp;
        logic gnt_exp;
        e.tag = tag;
        e.st  = st;
        e.to  = to;
        e.gc  = gc;
        sb_q.push_back(e);
        dma_req = d;
        busak_n = a;
        reset   = rst;
        @(posedge clk);
        #1;
        got      = sb_q.pop_front();
        rq_n_exp = !((got.st == S_REQ) || (got.st == S_GNT));
        gnt_exp  = (got.st == S_GNT);
        check({got.tag, ".state"},   32'(state),       32'(got.st));
        check({got.tag, ".busrq_n"}, 32'(busrq_n),     32'(rq_n_exp));
        check({got.tag, ".dma_gnt"}, 32'(dma_gnt),     32'(gnt_exp));
        check({got.tag, ".bus_sel"}, 32'(bus_sel),     32'(gnt_exp));
        check({got.tag, ".timeout"}, 32'(timeout_err), 32'(got.to));
        check({got.tag, ".gcount"},  32'(grant_count), 32'(got.gc));
    endtask

    // Seven more cooldown cycles after the first one, then the return to idle.
    task automatic cool_rest(input string tag, input logic d, input logic [7:0] gc);
        for (int i = 0; i < 7; i++)
            step($sformatf("%s_cool%0d", tag, i + 2), d, 1'b1, 1'b0, S_COOL, 1'b0, gc);
        step({tag, "_idle"}, d, 1'b1, 1'b0, S_IDLE, 1'b0, gc);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        dma_req = 1'b0;
        busak_n = 1'b1;

        // Reset state, including reset beating a pending request and acknowledge.
        step("rst0",    1'b0, 1'b1, 1'b1, S_IDLE, 1'b0, 8'd0);
        step("rst_req", 1'b1, 1'b0, 1'b1, S_IDLE, 1'b0, 8'd0);
        step("idle",    1'b0, 1'b1, 1'b0, S_IDLE, 1'b0, 8'd0);

        // Basic grant, released because dma_req drops.
        step("bas_req0", 1'b1, 1'b1, 1'b0, S_REQ,  1'b0, 8'd0);
        step("bas_req1", 1'b1, 1'b1, 1'b0, S_REQ,  1'b0, 8'd0);
        step("bas_gnt0", 1'b1, 1'b0, 1'b0, S_GNT,  1'b0, 8'd0);
        step("bas_gnt1", 1'b1, 1'b0, 1'b0, S_GNT,  1'b0, 8'd0);
        step("bas_rel0", 1'b0, 1'b0, 1'b0, S_REL,  1'b0, 8'd1);
        step("bas_rel1", 1'b0, 1'b0, 1'b0, S_REL,  1'b0, 8'd1);
        step("bas_cool1", 1'b0, 1'b1, 1'b0, S_COOL, 1'b0, 8'd1);
        cool_rest("bas", 1'b0, 8'd1);

        // Burst cap: exactly four grant cycles, then a cooldown that ignores dma_req.
        step("bur_req", 1'b1, 1'b1, 1'b0, S_REQ, 1'b0, 8'd1);
        for (int i = 0; i < 4; i++)
            step($sformatf("bur_gnt%0d", i), 1'b1, 1'b0, 1'b0, S_GNT, 1'b0, 8'd1);
        step("bur_rel0",  1'b1, 1'b0, 1'b0, S_REL,  1'b0, 8'd2);
        step("bur_rel1",  1'b1, 1'b0, 1'b0, S_REL,  1'b0, 8'd2);
        step("bur_cool1", 1'b1, 1'b1, 1'b0, S_COOL, 1'b0, 8'd2);
        cool_rest("bur", 1'b1, 8'd2);
        step("bur_rereq", 1'b1, 1'b1, 1'b0, S_REQ,  1'b0, 8'd2);
        step("bur_drop",  1'b0, 1'b1, 1'b0, S_IDLE, 1'b0, 8'd2);

        // Timeout: five unacknowledged REQ cycles. The timeout wins over the dropped request.
        for (int i = 0; i < 5; i++)
            step($sformatf("to_req%0d", i), 1'b1, 1'b1, 1'b0, S_REQ, 1'b0, 8'd2);
        step("to_pulse", 1'b0, 1'b1, 1'b0, S_IDLE, 1'b1, 8'd2);
        step("to_clear", 1'b0, 1'b1, 1'b0, S_IDLE, 1'b0, 8'd2);

        // Abort race: the acknowledge arrives in the same cycle dma_req drops.
        step("abt_req",   1'b1, 1'b1, 1'b0, S_REQ,  1'b0, 8'd2);
        step("abt_rel0",  1'b0, 1'b0, 1'b0, S_REL,  1'b0, 8'd2);
        step("abt_rel1",  1'b0, 1'b0, 1'b0, S_REL,  1'b0, 8'd2);
        step("abt_cool1", 1'b0, 1'b1, 1'b0, S_COOL, 1'b0, 8'd2);
        cool_rest("abt", 1'b0, 8'd2);

        // Protocol loss: busak_n rises during the grant, which still counts as a grant.
        step("pl_req",   1'b1, 1'b1, 1'b0, S_REQ,  1'b0, 8'd2);
        step("pl_gnt",   1'b1, 1'b0, 1'b0, S_GNT,  1'b0, 8'd2);
        step("pl_rel",   1'b1, 1'b1, 1'b0, S_REL,  1'b0, 8'd3);
        step("pl_cool1", 1'b1, 1'b1, 1'b0, S_COOL, 1'b0, 8'd3);
        cool_rest("pl", 1'b1, 8'd3);

        // Reset in the middle of a grant hands the bus straight back to the CPU.
        step("rg_req",  1'b1, 1'b1, 1'b0, S_REQ,  1'b0, 8'd3);
        step("rg_gnt",  1'b1, 1'b0, 1'b0, S_GNT,  1'b0, 8'd3);
        step("rg_rst",  1'b1, 1'b0, 1'b1, S_IDLE, 1'b0, 8'd0);
        step("rg_idle", 1'b0, 1'b1, 1'b0, S_IDLE, 1'b0, 8'd0);

        // grant_count saturates at 255.
        for (int g = 1; g <= 256; g++) begin
            logic [7:0] gc_prev;
            logic [7:0] gc_now;
            gc_prev = (g - 1 > 255) ? 8'hFF : 8'(g - 1);
            gc_now  = (g > 255) ? 8'hFF : 8'(g);
            step("sat_req",   1'b1, 1'b1, 1'b0, S_REQ,  1'b0, gc_prev);
            step("sat_gnt",   1'b1, 1'b0, 1'b0, S_GNT,  1'b0, gc_prev);
            step($sformatf("sat_rel%0d", g), 1'b0, 1'b0, 1'b0, S_REL, 1'b0, gc_now);
            step("sat_cool1", 1'b0, 1'b1, 1'b0, S_COOL, 1'b0, gc_now);
            cool_rest("sat", 1'b0, gc_now);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
